// File: rtl/proc_mon_pkg.sv
// Shared types and constants for the processor run monitor: FSM encoding,
// done-cause codes, default trace-entry field widths and a saturating counter helper.
package proc_mon_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } mon_state_e;

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_LIMIT = 2'd1;
   localparam logic [1:0] CAUSE_HALT  = 2'd2;

   localparam int CNT_W       = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_REG_W   = 5;
   localparam int DEF_STAMP_W = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/proc_run_monitor_trace_fifo.sv
// Synchronous FIFO for trace entries; extra pointer bit separates full from empty.
// A push while full is accepted only if a pop happens on the same cycle.
module trace_fifo #(
   parameter int WIDTH = 53,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/proc_run_monitor.sv
// Run-control and writeback trace monitor: counts cycles, retirements and stalls,
// buffers writeback events and stops on a cycle limit or a halted PC.
module proc_run_monitor
   import proc_mon_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int REG_W       = DEF_REG_W,
   parameter int DEPTH       = 16,
   parameter int STAMP_W     = DEF_STAMP_W,
   parameter int CYCLE_LIMIT = 100,
   parameter int HALT_WINDOW = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [DATA_W-1:0]  pc,
   input  logic               stall,
   input  logic               wb_en,
   input  logic [REG_W-1:0]   wb_reg,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               trace_valid,
   input  logic               trace_ready,
   output logic [REG_W-1:0]   trace_reg,
   output logic [DATA_W-1:0]  trace_data,
   output logic [STAMP_W-1:0] trace_stamp,
   output logic               overflow,
   output logic [31:0]        cycle_count,
   output logic [31:0]        retired_count,
   output logic [31:0]        stall_count,
   output logic               done,
   output logic [1:0]         done_cause
);
   localparam int ENTRY_W = REG_W + DATA_W + STAMP_W;
   localparam int HC_W    = $clog2(HALT_WINDOW + 1);
   localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(CYCLE_LIMIT - 1);
   localparam logic [HC_W-1:0]  HALT_HIT   = HC_W'(HALT_WINDOW);
   localparam logic [HC_W-1:0]  HC_ONE     = HC_W'(1);

   mon_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [HC_W-1:0]   halt_q, halt_d;
   logic [DATA_W-1:0] pc_prev_q, pc_prev_d;
   logic              pc_prev_vld_q, pc_prev_vld_d;
   logic              overflow_q, overflow_d;
   logic [1:0]        cause_q, cause_d;

   logic               capture, fifo_pop, fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] fifo_din, fifo_dout;

   assign capture  = (state_q == ST_RUN) && wb_en && (wb_reg != '0);
   assign fifo_din = {wb_reg, wb_data, cycle_q[STAMP_W-1:0]};
   assign fifo_pop = trace_valid && trace_ready;

   trace_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (capture),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign trace_valid   = !fifo_empty;
   assign trace_reg     = fifo_dout[ENTRY_W-1 -: REG_W];
   assign trace_data    = fifo_dout[STAMP_W +: DATA_W];
   assign trace_stamp   = fifo_dout[STAMP_W-1:0];
   assign overflow      = overflow_q;
   assign cycle_count   = cycle_q;
   assign retired_count = retired_q;
   assign stall_count   = stall_cnt_q;
   assign done          = (state_q == ST_DONE);
   assign done_cause    = cause_q;

   always_comb begin
      state_d       = state_q;
      cycle_d       = cycle_q;
      retired_d     = retired_q;
      stall_cnt_d   = stall_cnt_q;
      halt_d        = halt_q;
      pc_prev_d     = pc_prev_q;
      pc_prev_vld_d = pc_prev_vld_q;
      overflow_d    = overflow_q;
      cause_d       = cause_q;
      case (state_q)
         ST_RUN: begin
            cycle_d       = sat_inc(cycle_q);
            stall_cnt_d   = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
            retired_d     = capture ? sat_inc(retired_q) : retired_q;
            pc_prev_d     = pc;
            pc_prev_vld_d = 1'b1;
            if (capture && fifo_full && !fifo_pop) begin
               overflow_d = 1'b1;
            end else begin
               overflow_d = overflow_q;
            end
            // The first cycle after reset has no previous PC to compare against.
            if (!stall && pc_prev_vld_q && (pc == pc_prev_q)) begin
               halt_d = halt_q + HC_ONE;
            end else begin
               halt_d = '0;
            end
            if (cycle_q == LIMIT_LAST) begin
               state_d = ST_DRAIN;
               cause_d = CAUSE_LIMIT;
            end else if (halt_d == HALT_HIT) begin
               state_d = ST_DRAIN;
               cause_d = CAUSE_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            state_d = fifo_empty ? ST_DONE : ST_DRAIN;
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         cycle_q       <= '0;
         retired_q     <= '0;
         stall_cnt_q   <= '0;
         halt_q        <= '0;
         pc_prev_q     <= '0;
         pc_prev_vld_q <= 1'b0;
         overflow_q    <= 1'b0;
         cause_q       <= CAUSE_NONE;
      end else begin
         state_q       <= state_d;
         cycle_q       <= cycle_d;
         retired_q     <= retired_d;
         stall_cnt_q   <= stall_cnt_d;
         halt_q        <= halt_d;
         pc_prev_q     <= pc_prev_d;
         pc_prev_vld_q <= pc_prev_vld_d;
         overflow_q    <= overflow_d;
         cause_q       <= cause_d;
      end
   end

endmodule
